touchpad_adc_controller: RTL and testbench
==========================================

# touchpad_adc_controller

- Drives an AD7873-class touchscreen ADC over its 4-wire serial interface (DCLK/CS#/DIN/DOUT, plus BUSY).
- Continuously converts X, Y and Z1 in round-robin order.
- Truncates each 12-bit result to 9 bits and optionally box-averages it.
- Presents stable 9-bit `x`, `y`, `z` coordinates to the display/UI logic in the `cclk` domain.

## Interface
- `DCLK_DIV`, default 50: `cclk` cycles per `touch_clk` half-period; DCLK = cclk/(2·DCLK_DIV), 1 MHz at 100 MHz.
- `AVG_LOG2`, default 4: log2 of samples averaged per axis (16).
- `IDLE_CLKS`, default 2: DCLK periods with CS# high between frames.
- `cclk` input 1: system clock; the only clock.
- `rstb` input 1: reset, asynchronous, active-low.
- `touch_busy` input 1: ADC BUSY; monitored only, does not gate the frame.
- `data_in` input 1: ADC DOUT.
- `touch_clk` output 1: ADC DCLK.
- `touch_csb` output 1: ADC chip select, active-low.
- `data_out` output 1: ADC DIN.
- `x`, `y`, `z` output 9 each: filtered coordinates.

## Operation
- **Reset values:** `touch_clk`=0, `touch_csb`=1, `data_out`=0, `x`/`y`/`z`=0, channel=X, accumulators and counters cleared.
- **Channel order:** X, then Y, then Z1, then back to X, indefinitely.
- **Control byte:** sent MSB first as S=1, A2..A0, MODE=0 (12-bit), SER/DFR=0 (differential), PD1..PD0=00.
  - X = 0xD0, Y = 0x90, Z1 = 0xB0.
- **State machine:**
  - IDLE: CS# high for IDLE_CLKS DCLK periods → SETUP.
  - SETUP: CS# low for one half-period, DCLK low → CMD.
  - CMD: 8 DCLK periods → ACQ.
  - ACQ: 16 DCLK periods → DONE.
  - DONE: one `cclk`; raise CS#, latch the sample, advance the channel → IDLE.
- **Sample capture:** 12-bit result = bits captured on ACQ rising edges 2..13 (DCLK 10..21 of the frame), MSB first. Edges 14..16 are ignored padding.
- **Truncation:** sample9 = result[11:3].
- **Averaging:** each axis has an accumulator of width 9+AVG_LOG2.
  - After 2^AVG_LOG2 samples for that axis, output = acc >> AVG_LOG2 (floor); the accumulator then clears.
  - Outputs change only at that instant and hold otherwise.
- `touch_busy` is not required for sequencing; a frame is always a fixed 24 DCLK periods.

## Timing
- DCLK half-period = DCLK_DIV `cclk` cycles; 50% duty; `touch_clk` toggles only while CS# is low.
- `data_out` changes on the `cclk` where `touch_clk` falls (and at SETUP for bit 7), so it is stable at each rising edge. It is 0 outside CMD.
- `data_in` is sampled on the `cclk` where `touch_clk` rises.
- **Frame length:** (IDLE_CLKS + 24.5)·2·DCLK_DIV `cclk` cycles + 1 for DONE.
  - Default: 2651 `cclk` cycles.
- **Output latency:** one axis output updates every 3·2^AVG_LOG2 frames.
  - First `x` update at the end of the 46th frame (the 16th X frame).
- **Reset mid-frame:** CS# goes high and `touch_clk` goes low asynchronously; the partial sample is discarded; the next frame is X.

## Configuration
- Macro `TOUCHPAD_AVERAGE_EN`:
  - Defined: averaging as described above.
  - Undefined: accumulators are removed, `AVG_LOG2` is ignored, and each output takes sample9 of its axis at that axis's DONE.

## Structure
- Package `touchpad_pkg`:
  - channel enum {CH_X, CH_Y, CH_Z1};
  - control-byte constants 0xD0/0x90/0xB0;
  - `CMD_BITS`=8, `FRAME_CLKS`=24, first/last capture edge indices (2 and 13);
  - state enum {IDLE, SETUP, CMD, ACQ, DONE}.
- Sub-module `touch_averager`: accumulator, sample counter and output register, instantiated once per axis.

## Test plan
- Hold `rstb`=0 → `touch_csb`=1, `touch_clk`=0, `x`/`y`/`z`=0; release → first CS# fall after 2 idle DCLK periods; first control byte on `data_out` = 0xD0.
- Free run → control bytes repeat 0xD0, 0x90, 0xB0; `touch_clk` period 1000 ns; 24 rising edges per CS#-low window.
- ADC model returning constant 0xABC → `x`=0x157 at the end of frame 46; `y`/`z` update one and two frames later.
- ADC returning X samples alternating 0x000/0x7F8 → `x`=0x07F (floor of the average of 0x000 and 0x0FF).
- Noisy ADC model over 100 000 DCLKs → outputs within ±2 LSB of the noise-free value; no X/Y/Z channel skipped.
- Assert `rstb` during ACQ of a Y frame → CS# high within one `cclk`, outputs 0; after release the next frame is 0xD0.

Source files
------------

// File: rtl/touchpad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : touchpad_pkg
// Purpose  : Shared types and constants for the AD7873-class touchscreen ADC
//            controller: channel and FSM state enums, control bytes and
//            frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
package touchpad_pkg;

  typedef enum logic [1:0] {CH_X, CH_Y, CH_Z1} channel_t;

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ACQ, DONE} state_t;

  // S=1, A2..A0, MODE=0 (12-bit), SER/DFR=0, PD1..PD0=00
  localparam logic [7:0] CTRL_X  = 8'hD0;
  localparam logic [7:0] CTRL_Y  = 8'h90;
  localparam logic [7:0] CTRL_Z1 = 8'hB0;

  localparam int CMD_BITS   = 8;   // DCLK periods spent shifting the control byte
  localparam int FRAME_CLKS = 24;  // DCLK periods per CS#-low window
  localparam int CAP_FIRST  = 2;   // first ACQ rising edge carrying result MSB
  localparam int CAP_LAST   = 13;  // ACQ rising edge carrying result LSB

  function automatic logic [7:0] ctrl_byte(input channel_t ch);
    case (ch)
      CH_X:    return CTRL_X;
      CH_Y:    return CTRL_Y;
      default: return CTRL_Z1;
    endcase
  endfunction

  function automatic channel_t next_channel(input channel_t ch);
    case (ch)
      CH_X:    return CH_Y;
      CH_Y:    return CH_Z1;
      default: return CH_X;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/touch_averager.sv
`default_nettype none
// ============================================================================
// Module   : touch_averager
// Purpose  : Per-axis filter. With TOUCHPAD_AVERAGE_EN defined it box-averages
//            2^AVG_LOG2 samples and updates the output once per block;
//            otherwise the output simply follows each new sample.
// Ports    : cclk, rstb (async active-low), sample_valid/sample (9-bit input
//            sample strobe), avg_out (9-bit held output).
// Macro    : TOUCHPAD_AVERAGE_EN
// Revision : 1.0 - initial release
// ============================================================================
module touch_averager #(
  parameter int AVG_LOG2 = 4
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic       sample_valid,
  input  logic [8:0] sample,
  output logic [8:0] avg_out
);

`ifdef TOUCHPAD_AVERAGE_EN
  localparam int ACC_W = 9 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;

  assign acc_sum = acc + ACC_W'(sample);

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      acc     <= '0;
      cnt     <= '0;
      avg_out <= '0;
    end else if (sample_valid) begin
      // Last sample of the block: publish floor(sum / 2^AVG_LOG2) and restart.
      if (cnt == CNT_W'((1 << AVG_LOG2) - 1)) begin
        avg_out <= acc_sum[ACC_W-1:AVG_LOG2];
        acc     <= '0;
        cnt     <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      avg_out <= '0;
    end else if (sample_valid) begin
      avg_out <= sample;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/touchpad_adc_controller.sv
`default_nettype none
// ============================================================================
// Module   : touchpad_adc_controller
// Purpose  : Drives an AD7873-class touchscreen ADC over DCLK/CS#/DIN/DOUT,
//            converting X, Y, Z1 round-robin, truncating each 12-bit result
//            to 9 bits and presenting filtered x/y/z in the cclk domain.
// Ports    : cclk (system clock), rstb (async active-low reset),
//            touch_busy (ADC BUSY, monitored only), data_in (ADC DOUT),
//            touch_clk (DCLK), touch_csb (CS#), data_out (ADC DIN),
//            x/y/z (9-bit coordinates).
// Macro    : TOUCHPAD_AVERAGE_EN enables box averaging in touch_averager.
// Revision : 1.0 - initial release
// ============================================================================
module touchpad_adc_controller
  import touchpad_pkg::*;
#(
  parameter int DCLK_DIV  = 50,
  parameter int AVG_LOG2  = 4,
  parameter int IDLE_CLKS = 2
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic       touch_busy,
  input  logic       data_in,
  output logic       touch_clk,
  output logic       touch_csb,
  output logic       data_out,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic [8:0] z
);

  localparam int DIV_W       = (DCLK_DIV > 1) ? $clog2(DCLK_DIV) : 1;
  localparam int IDLE_HALVES = 2 * IDLE_CLKS;
  localparam int CMD_HALVES  = 2 * CMD_BITS;
  localparam int ACQ_HALVES  = 2 * (FRAME_CLKS - CMD_BITS);
  localparam int HALF_MAX    = (IDLE_HALVES > ACQ_HALVES) ? IDLE_HALVES : ACQ_HALVES;
  localparam int HALF_W      = $clog2(HALF_MAX);
  // ACQ rising edge j occurs on the tick that ends ACQ half-period 2j-3.
  localparam int CAP_LO      = 2 * CAP_FIRST - 3;
  localparam int CAP_HI      = 2 * CAP_LAST - 3;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                tclk_q, tclk_d;
  logic                csb_q, csb_d;
  logic                dout_q, dout_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [11:0]         shift_q, shift_d;
  channel_t            ch_q, ch_d;
  logic                sample_valid;
  logic                tick;
  logic [7:0]          ctrl;
  logic                unused_ok;

  // BUSY is not needed for sequencing; low result bits are truncated away.
  assign unused_ok = ^{touch_busy, shift_q[2:0]};

  assign tick = (div_q == DIV_W'(DCLK_DIV - 1));
  assign ctrl = ctrl_byte(ch_q);

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + 1'b1;
    half_d       = tick ? half_q + 1'b1 : half_q;
    tclk_d       = tclk_q;
    csb_d        = csb_q;
    dout_d       = dout_q;
    cmd_d        = cmd_q;
    shift_d      = shift_q;
    ch_d         = ch_q;
    sample_valid = 1'b0;

    case (state_q)
      IDLE: begin
        csb_d  = 1'b1;
        tclk_d = 1'b0;
        dout_d = 1'b0;
        if (tick && half_q == HALF_W'(IDLE_HALVES - 1)) begin
          state_d = SETUP;
          half_d  = '0;
          csb_d   = 1'b0;
          dout_d  = ctrl[7];
          cmd_d   = {ctrl[6:0], 1'b0};
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = CMD;
          half_d  = '0;
          tclk_d  = 1'b1;
        end
      end
      CMD: begin
        if (tick) begin
          tclk_d = ~tclk_q;
          // Next command bit goes out on the falling edge; zeros follow bit 0.
          if (tclk_q) begin
            dout_d = cmd_q[7];
            cmd_d  = {cmd_q[6:0], 1'b0};
          end
          if (half_q == HALF_W'(CMD_HALVES - 1)) begin
            state_d = ACQ;
            half_d  = '0;
          end
        end
      end
      ACQ: begin
        if (tick) begin
          if (half_q == HALF_W'(ACQ_HALVES - 1)) begin
            // The would-be 25th rising edge is suppressed; frame ends low.
            state_d = DONE;
            half_d  = '0;
            tclk_d  = 1'b0;
          end else begin
            tclk_d = ~tclk_q;
            if (half_q[0] && half_q >= HALF_W'(CAP_LO) && half_q <= HALF_W'(CAP_HI)) begin
              shift_d = {shift_q[10:0], data_in};
            end
          end
        end
      end
      DONE: begin
        state_d      = IDLE;
        div_d        = '0;
        half_d       = '0;
        csb_d        = 1'b1;
        sample_valid = 1'b1;
        ch_d         = next_channel(ch_q);
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        half_d  = '0;
        csb_d   = 1'b1;
        tclk_d  = 1'b0;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      tclk_q  <= 1'b0;
      csb_q   <= 1'b1;
      dout_q  <= 1'b0;
      cmd_q   <= '0;
      shift_q <= '0;
      ch_q    <= CH_X;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      tclk_q  <= tclk_d;
      csb_q   <= csb_d;
      dout_q  <= dout_d;
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      ch_q    <= ch_d;
    end
  end

  assign touch_clk = tclk_q;
  assign touch_csb = csb_q;
  assign data_out  = dout_q;

  logic [8:0] axis_out [3];

  for (genvar i = 0; i < 3; i++) begin : g_axis
    touch_averager #(
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .cclk         (cclk),
      .rstb         (rstb),
      .sample_valid (sample_valid && (ch_q == channel_t'(i))),
      .sample       (shift_q[11:3]),
      .avg_out      (axis_out[i])
    );
  end

  assign x = axis_out[0];
  assign y = axis_out[1];
  assign z = axis_out[2];

endmodule
`default_nettype wire

// File: tb/tb_touchpad_adc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_touchpad_adc_controller
// Purpose  : Self-checking bench: ADC serial model, frame-level reference
//            model of the x/y/z filter, table-driven constant-input vectors,
//            random-noise run and mid-frame reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_touchpad_adc_controller;

  localparam int DIV       = 3;
  localparam int L         = 2;
  localparam int IDLE      = 2;
  localparam int N         = 1 << L;
  localparam int FRAME_CYC = (2 * IDLE + 49) * DIV + 1;

  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  logic       touch_busy = 1'b0;
  logic       data_in = 1'b0;
  logic       touch_clk, touch_csb, data_out;
  logic [8:0] x, y, z;

  always #5 cclk = ~cclk;

  touchpad_adc_controller #(
    .DCLK_DIV  (DIV),
    .AVG_LOG2  (L),
    .IDLE_CLKS (IDLE)
  ) dut (
    .cclk       (cclk),
    .rstb       (rstb),
    .touch_busy (touch_busy),
    .data_in    (data_in),
    .touch_clk  (touch_clk),
    .touch_csb  (touch_csb),
    .data_out   (data_out),
    .x          (x),
    .y          (y),
    .z          (z)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ADC model + reference model state ----------------
  logic [7:0]  ctrl_exp [3];
  logic [11:0] adc_val  [3];
  bit          alt_en, noise_en, alt_ph;
  logic [11:0] frame_val;
  logic [7:0]  cmd_sh, first_cmd;
  int          rise_r, last_rise, cyc, high_cnt, frame_cnt, exp_ch;
  bit          prev_tclk, prev_csb, period_bad, dout_bad, idle_bad, first_after_rst;
  int          sum [3];
  int          cnt [3];
  logic [8:0]  exp_out [3];
  int          dec_ch;

  always @(posedge cclk) begin
    #1;
    cyc++;
    if (!rstb) begin
      prev_tclk = 1'b0; prev_csb = 1'b1; rise_r = 0; frame_cnt = 0; exp_ch = 0;
      high_cnt = 0; first_after_rst = 1'b1; alt_ph = 1'b0; idle_bad = 1'b0;
      first_cmd = 8'h00; data_in = 1'b0;
      for (int i = 0; i < 3; i++) begin sum[i] = 0; cnt[i] = 0; exp_out[i] = 9'h000; end
    end else begin
      if (!prev_csb && touch_csb) begin
        chk("rises_per_frame", rise_r, 24);
        chk("ctrl_byte", cmd_sh, ctrl_exp[exp_ch]);
        chk("dclk_period", period_bad, 0);
        chk("din_zero_after_cmd", dout_bad, 0);
`ifdef TOUCHPAD_AVERAGE_EN
        sum[exp_ch] += int'(frame_val[11:3]);
        cnt[exp_ch]++;
        if (cnt[exp_ch] == N) begin
          exp_out[exp_ch] = 9'(sum[exp_ch] / N);
          sum[exp_ch] = 0;
          cnt[exp_ch] = 0;
        end
`else
        exp_out[exp_ch] = frame_val[11:3];
`endif
        chk("x_at_frame_end", x, exp_out[0]);
        chk("y_at_frame_end", y, exp_out[1]);
        chk("z_at_frame_end", z, exp_out[2]);
        frame_cnt++;
        exp_ch = (exp_ch + 1) % 3;
        high_cnt = 0;
      end
      if (prev_csb && !touch_csb) begin
        if (!first_after_rst) chk("idle_gap_cycles", high_cnt, 2 * IDLE * DIV);
        chk("idle_quiet", idle_bad, 0);
        chk("x_hold", x, exp_out[0]);
        chk("y_hold", y, exp_out[1]);
        chk("z_hold", z, exp_out[2]);
        first_after_rst = 1'b0; idle_bad = 1'b0;
        rise_r = 0; cmd_sh = 8'h00; period_bad = 1'b0; dout_bad = 1'b0;
        touch_busy = 1'($urandom_range(0, 1));
      end
      if (touch_csb) begin
        high_cnt++;
        if (touch_clk || data_out) idle_bad = 1'b1;
      end else begin
        if (touch_clk && !prev_tclk) begin
          rise_r++;
          if (rise_r > 1 && cyc - last_rise != 2 * DIV) period_bad = 1'b1;
          last_rise = cyc;
          if (rise_r <= 8) cmd_sh = {cmd_sh[6:0], data_out};
          if (rise_r == 8) begin
            case (cmd_sh)
              8'hD0:   dec_ch = 0;
              8'h90:   dec_ch = 1;
              8'hB0:   dec_ch = 2;
              default: dec_ch = exp_ch;
            endcase
            if (frame_cnt == 0) first_cmd = cmd_sh;
            if (noise_en) frame_val = 12'($urandom_range(0, 4095));
            else if (dec_ch == 0 && alt_en) begin
              frame_val = alt_ph ? 12'h7F8 : 12'h000;
              alt_ph = ~alt_ph;
            end else frame_val = adc_val[dec_ch];
          end
          // Present the bit the DUT will sample on the next rising edge.
          if (rise_r >= 9 && rise_r <= 20) data_in = frame_val[20 - rise_r];
          else data_in = 1'($urandom_range(0, 1));
        end
        if (rise_r >= 9 && data_out) dout_bad = 1'b1;
      end
      prev_tclk = touch_clk;
      prev_csb  = touch_csb;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rstb = 1'b0;
    repeat (3) @(posedge cclk);
    #2;
    chk("rst_csb", touch_csb, 1);
    chk("rst_tclk", touch_clk, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_xyz", {x, y, z}, 27'h0);
    @(negedge cclk);
    rstb = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = n * (FRAME_CYC + 20) + 50;
    while (frame_cnt < n && budget > 0) begin
      @(posedge cclk);
      budget--;
    end
    #2;
    if (frame_cnt < n) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frame_cnt, n);
    end
  endtask

  typedef struct {
    logic [11:0] vx, vy, vz;
    bit          alt;
    logic [8:0]  ex, ey, ez;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int budget;
    ctrl_exp[0] = 8'hD0; ctrl_exp[1] = 8'h90; ctrl_exp[2] = 8'hB0;
    alt_en = 1'b0; noise_en = 1'b0;

    vecs[0] = '{12'hABC, 12'hABC, 12'hABC, 1'b0, 9'h157, 9'h157, 9'h157};
    vecs[1] = '{12'h123, 12'h456, 12'hFFF, 1'b0, 9'h024, 9'h08A, 9'h1FF};
    vecs[2] = '{12'h000, 12'h007, 12'h008, 1'b0, 9'h000, 9'h000, 9'h001};
`ifdef TOUCHPAD_AVERAGE_EN
    vecs[3] = '{12'h000, 12'h7F8, 12'h800, 1'b1, 9'h07F, 9'h0FF, 9'h100};
`else
    vecs[3] = '{12'h000, 12'h7F8, 12'h800, 1'b1, 9'h0FF, 9'h0FF, 9'h100};
`endif

    for (int v = 0; v < 4; v++) begin
      adc_val[0] = vecs[v].vx; adc_val[1] = vecs[v].vy; adc_val[2] = vecs[v].vz;
      alt_en = vecs[v].alt;
      do_reset();
      wait_frames(3 * N);
      chk("first_ctrl_byte", first_cmd, 8'hD0);
      chk("vec_x", x, vecs[v].ex);
      chk("vec_y", y, vecs[v].ey);
      chk("vec_z", z, vecs[v].ez);
    end

    // Reset in the middle of a Y acquisition.
    budget = 4 * FRAME_CYC;
    while (!(exp_ch == 1 && rise_r >= 12) && budget > 0) begin
      @(posedge cclk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL wait_y_acq: got timeout expected Y frame");
    end
    @(posedge cclk);
    #3;
    rstb = 1'b0;
    #1;
    chk("midrst_csb", touch_csb, 1);
    chk("midrst_tclk", touch_clk, 0);
    chk("midrst_xyz", {x, y, z}, 27'h0);
    repeat (2) @(negedge cclk);
    rstb = 1'b1;
    wait_frames(1);
    chk("ctrl_after_midrst", first_cmd, 8'hD0);

    // Random ADC data, exact reference model comparison every frame.
    noise_en = 1'b1;
    do_reset();
    wait_frames(12 * N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
